// File: rtl/uart_pkt_rx.sv
// Packet deframer behind the UART receive FIFO: sync hunt, CMD/LEN/payload/CHK collection, valid/ack hand-off.
// Optional inter-byte timeout is built when UART_PKT_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | hunting for SYNC, non-sync bytes discarded
// CMD   | next pop is the command byte
// LEN   | next pop is the payload length
// DATA  | collecting payload bytes into the buffer
// CHK   | next pop is compared with the running XOR
// HOLD  | packet presented, waiting for pkt_ack, no pops
`timescale 1ns/1ps
module uart_pkt_rx #(
  parameter int          MAX_LEN = 16,
  parameter int          TIMEOUT = 50000,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  output logic       pkt_valid,
  input  logic       pkt_ack,
  output logic [7:0] pkt_cmd,
  output logic [7:0] pkt_len,
  input  logic [7:0] pl_addr,
  output logic [7:0] pl_data,
  output logic       chk_err,
  output logic       len_err,
  output logic       tmo_err,
  output logic       busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_LEN  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_HOLD = 3'd5;

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT < 1) begin : g_bad_param
    $error("uart_pkt_rx: MAX_LEN must be 1..255 and TIMEOUT at least 1");
  end

  logic [2:0] state;
  logic [7:0] cmd_r;
  logic [7:0] len_r;
  logic [7:0] xor_r;
  logic [7:0] idx;
  logic [7:0] buf_mem [MAX_LEN];
  logic       pop;
  logic       tmo_fire;

  // reset gates the pop so no byte is lost while the block is held in reset
  assign pop     = reset & ~rx_empty & (state != S_HOLD);
  assign rd_uart = pop;
  assign busy    = (state != S_IDLE);
  assign pl_data = (pl_addr < pkt_len) ? buf_mem[pl_addr[AW-1:0]] : 8'h00;

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] tmo_cnt;
  logic          tmo_err_r;
  logic          in_pkt;

  assign in_pkt   = (state == S_CMD) || (state == S_LEN) || (state == S_DATA) || (state == S_CHK);
  assign tmo_fire = in_pkt & ~pop & (tmo_cnt == TW'(TIMEOUT - 1));
  assign tmo_err  = tmo_err_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt   <= '0;
      tmo_err_r <= 1'b0;
    end else begin
      tmo_err_r <= tmo_fire;
      if (!in_pkt || pop || tmo_fire)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + 1'b1;
    end
  end
`else
  assign tmo_fire = 1'b0;
  assign tmo_err  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (state == S_DATA && pop)
      buf_mem[idx[AW-1:0]] <= r_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pkt_valid <= 1'b0;
      pkt_cmd   <= 8'h00;
      pkt_len   <= 8'h00;
      chk_err   <= 1'b0;
      len_err   <= 1'b0;
      cmd_r     <= 8'h00;
      len_r     <= 8'h00;
      xor_r     <= 8'h00;
      idx       <= 8'h00;
    end else begin
      chk_err <= 1'b0;
      len_err <= 1'b0;
      if (tmo_fire) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (pop && r_data == SYNC)
              state <= S_CMD;
          end
          S_CMD: begin
            if (pop) begin
              cmd_r <= r_data;
              xor_r <= r_data;
              state <= S_LEN;
            end
          end
          S_LEN: begin
            if (pop) begin
              len_r <= r_data;
              xor_r <= xor_r ^ r_data;
              if (r_data > MAX_LEN_B) begin
                len_err <= 1'b1;
                state   <= S_IDLE;
              end else if (r_data == 8'h00) begin
                state <= S_CHK;
              end else begin
                idx   <= 8'h00;
                state <= S_DATA;
              end
            end
          end
          S_DATA: begin
            if (pop) begin
              xor_r <= xor_r ^ r_data;
              idx   <= idx + 8'd1;
              if (idx == len_r - 8'd1)
                state <= S_CHK;
            end
          end
          S_CHK: begin
            if (pop) begin
              if (r_data == xor_r) begin
                pkt_cmd   <= cmd_r;
                pkt_len   <= len_r;
                pkt_valid <= 1'b1;
                state     <= S_HOLD;
              end else begin
                chk_err <= 1'b1;
                state   <= S_IDLE;
              end
            end
          end
          S_HOLD: begin
            if (pkt_ack) begin
              pkt_valid <= 1'b0;
              state     <= S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_pkt_rx.sv
// Bench for uart_pkt_rx: FIFO model feeds bytes, expected packets/errors go through a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_pkt_rx;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx_empty;
  logic [7:0] r_data;
  logic       rd_uart;
  logic       pkt_valid;
  logic       pkt_ack;
  logic [7:0] pkt_cmd;
  logic [7:0] pkt_len;
  logic [7:0] pl_addr;
  logic [7:0] pl_data;
  logic       chk_err;
  logic       len_err;
  logic       tmo_err;
  logic       busy;

  always #5 clk = ~clk;

  uart_pkt_rx #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT), .SYNC(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .pkt_valid(pkt_valid), .pkt_ack(pkt_ack), .pkt_cmd(pkt_cmd), .pkt_len(pkt_len),
    .pl_addr(pl_addr), .pl_data(pl_data), .chk_err(chk_err), .len_err(len_err),
    .tmo_err(tmo_err), .busy(busy)
  );

  // kind: 0 packet, 1 chk_err, 2 len_err, 3 tmo_err
  typedef struct {
    int         kind;
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] pl [MAX_LEN];
  } exp_t;

  exp_t       sb_q [$];
  logic [7:0] fifo_q [$];
  logic [7:0] pl_buf [MAX_LEN];

  int n_err = 0;
  int n_checks = 0;
  int cyc = 0;
  int last_pop = -10;
  int run = 0;
  int max_run = 0;
  int npop = 0;
  int ack_delay = 0;
  bit mon_busy = 1'b0;
  bit prev_chk = 1'b0;
  bit prev_len = 1'b0;
  bit prev_tmo = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic push_evt(input int kind);
    exp_t e;
    e.kind = kind;
    e.cmd  = 8'h00;
    e.len  = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) e.pl[i] = 8'h00;
    sb_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] cmd, input int len, input bit bad);
    exp_t       e;
    logic [7:0] x;
    e.kind = bad ? 1 : 0;
    e.cmd  = cmd;
    e.len  = 8'(len);
    e.pl   = pl_buf;
    x = cmd ^ 8'(len);
    sb_q.push_back(e);
    push_byte(8'hA5);
    push_byte(cmd);
    push_byte(8'(len));
    for (int i = 0; i < len; i++) begin
      push_byte(pl_buf[i]);
      x = x ^ pl_buf[i];
    end
    push_byte(bad ? ~x : x);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(fifo_q.size() == 0 && sb_q.size() == 0 && !busy && !pkt_valid && !mon_busy) && n < 600) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_done"}, 32'(n < 600), 1);
  endtask

  // FIFO model: pop decision sampled mid-cycle, head byte updated just after the edge
  initial begin
    bit pop_now;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    forever begin
      @(negedge clk);
      pop_now = rd_uart;
      @(posedge clk);
      cyc++;
      if (pop_now) begin
        if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        npop++;
        run = (last_pop == cyc - 1) ? run + 1 : 1;
        last_pop = cyc;
        if (run > max_run) max_run = run;
      end
      #1;
      rx_empty = (fifo_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : fifo_q[0];
    end
  end

  task automatic handle_evt(input int kind);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("unexpected_evt", kind, 0);
    end else begin
      e = sb_q.pop_front();
      check_val("evt_kind", kind, e.kind);
      check_val("evt_no_valid", pkt_valid, 0);
      if (kind == 3) begin
        check_val("tmo_lat", cyc - last_pop, TIMEOUT);
        check_val("tmo_busy", busy, 0);
      end else begin
        check_val("evt_lat", cyc - last_pop, 0);
      end
    end
  endtask

  task automatic consume_pkt();
    exp_t e;
    int   top;
    if (sb_q.size() == 0) begin
      check_val("unexpected_pkt", 1, 0);
      e.kind = 0;
      e.cmd  = 8'h00;
      e.len  = 8'h00;
      for (int i = 0; i < MAX_LEN; i++) e.pl[i] = 8'h00;
    end else begin
      e = sb_q.pop_front();
    end
    check_val("pkt_kind", 0, e.kind);
    check_val("pv_lat", cyc - last_pop, 0);
    check_val("pkt_cmd", pkt_cmd, e.cmd);
    check_val("pkt_len", pkt_len, e.len);
    top = int'(e.len) + 1;
    for (int i = 0; i <= top; i++) begin
      pl_addr = (i == top) ? 8'hFF : 8'(i);
      #1;
      check_val("pl_data", pl_data, (i < int'(e.len)) ? e.pl[i] : 8'h00);
      check_val("hold_rd", rd_uart, 0);
      @(negedge clk);
    end
    for (int i = 0; i < ack_delay; i++) begin
      check_val("hold_valid", pkt_valid, 1);
      check_val("hold_rd", rd_uart, 0);
      @(negedge clk);
    end
    pkt_ack = 1'b1;
    @(posedge clk);
    #1 pkt_ack = 1'b0;
    @(negedge clk);
    check_val("ack_clr", pkt_valid, 0);
  endtask

  initial begin
    pkt_ack = 1'b0;
    pl_addr = 8'h00;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (prev_chk) check_val("chk_err_width", chk_err, 0);
        if (prev_len) check_val("len_err_width", len_err, 0);
        if (prev_tmo) check_val("tmo_err_width", tmo_err, 0);
        prev_chk = chk_err;
        prev_len = len_err;
        prev_tmo = tmo_err;
        if (chk_err) handle_evt(1);
        if (len_err) handle_evt(2);
        if (tmo_err) handle_evt(3);
        if (pkt_valid) begin
          mon_busy = 1'b1;
          consume_pkt();
          mon_busy = 1'b0;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0;
    int n;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_rd_uart", rd_uart, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_valid", pkt_valid, 0);
    check_val("rst_cmd", pkt_cmd, 0);
    check_val("rst_len", pkt_len, 0);
    check_val("rst_errs", {chk_err, len_err, tmo_err}, 0);
    reset = 1'b1;
    @(negedge clk);
    check_val("idle_busy", busy, 0);

    // basic two-byte packet, back-to-back pops
    max_run = 0;
    n0 = npop;
    pl_buf[0] = 8'h33;
    pl_buf[1] = 8'h44;
    send_frame(8'h10, 2, 1'b0);
    wait_idle("t1");
    check_val("t1_run", max_run, 6);
    check_val("t1_pops", npop - n0, 6);

    // leading garbage, zero-length packet, held with bytes waiting
    n0 = npop;
    push_byte(8'h00);
    push_byte(8'hFF);
    send_frame(8'h07, 0, 1'b0);
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    ack_delay = 20;
    wait_idle("t2");
    ack_delay = 0;
    check_val("t2_pops", npop - n0, 9);

    // bad checksum then a good frame
    push_byte(8'hA5);
    push_byte(8'h10);
    push_byte(8'h01);
    push_byte(8'h55);
    push_byte(8'h00);
    push_evt(1);
    pl_buf[0] = 8'h9C;
    pl_buf[1] = 8'hA5;
    pl_buf[2] = 8'h01;
    send_frame(8'h42, 3, 1'b0);
    wait_idle("t3");

    // oversize length, following bytes hunted, then max-length packet with SYNC in payload
    push_byte(8'hA5);
    push_byte(8'h01);
    push_byte(8'h11);
    push_evt(2);
    push_byte(8'h11);
    push_byte(8'h22);
    for (int i = 0; i < MAX_LEN; i++) pl_buf[i] = (i == 5) ? 8'hA5 : 8'(8'h30 + i);
    send_frame(8'hC3, MAX_LEN, 1'b0);
    wait_idle("t4");

    // random frames queued back to back, one with a corrupted checksum
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < MAX_LEN; i++) pl_buf[i] = 8'($urandom);
      send_frame(8'($urandom), int'($urandom_range(1, MAX_LEN)), k == 2);
    end
    wait_idle("t5");

    // stall mid-packet
    push_byte(8'hA5);
    push_byte(8'h20);
`ifdef UART_PKT_TIMEOUT_EN
    push_evt(3);
`endif
    repeat (130) @(negedge clk);
`ifdef UART_PKT_TIMEOUT_EN
    check_val("stall_busy", busy, 0);
`else
    check_val("stall_busy", busy, 1);
    check_val("stall_no_tmo", tmo_err, 0);
`endif
    check_val("stall_sb", sb_q.size(), 0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // reset while collecting payload, with bytes still in the FIFO
    n0 = npop;
    push_byte(8'hA5);
    push_byte(8'h30);
    push_byte(8'h05);
    push_byte(8'h11);
    push_byte(8'h22);
    push_byte(8'h33);
    push_byte(8'h44);
    push_byte(8'h55);
    n = 0;
    while (npop < n0 + 5 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("mid_reach", 32'(npop >= n0 + 5), 1);
    check_val("mid_busy_pre", busy, 1);
    #2 reset = 1'b0;
    #1;
    check_val("mid_busy", busy, 0);
    check_val("mid_rd", rd_uart, 0);
    check_val("mid_valid", pkt_valid, 0);
    fifo_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) pl_buf[i] = 8'(8'hE0 + i);
    send_frame(8'h5A, 4, 1'b0);
    wait_idle("t6");
    check_val("end_sb", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
